// File: rtl/jt51_lite.sv
// jt51_lite: reduced OPM-style sound block with register port, timers A/B, IRQ, busy flag and eight panned square-wave channels.
// Optional macro CSM_EN: timer A overflow keys on all channels for one sample when reg 0x14 bit 7 is set.
module jt51_lite #(
  parameter logic signed [15:0] CH_AMP = 16'sd2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        cen_p1,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic        a0,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        ct1,
  output logic        ct2,
  output logic        irq_n,
  output logic        sample,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic [15:0] xleft,
  output logic [15:0] xright,
  output logic [15:0] dacleft,
  output logic [15:0] dacright
);

  logic [7:0]  addr_q, addr_d;
  logic        busy_q, busy_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic [4:0]  tcnt_q, tcnt_d;
  logic        sample_q, sample_d;
  logic [7:0]  key_q, key_d;
  logic [9:0]  clka_q, clka_d;
  logic [7:0]  clkb_q, clkb_d;
  logic [4:0]  ctrl_q, ctrl_d;   // {csm, en_b, en_a, run_b, run_a}
  logic [1:0]  ct_q, ct_d;
  logic [9:0]  cnt_a_q, cnt_a_d;
  logic [7:0]  cnt_b_q, cnt_b_d;
  logic [3:0]  pre_b_q, pre_b_d;
  logic        flag_a_q, flag_a_d;
  logic        flag_b_q, flag_b_d;
  logic        csm_q, csm_d;
  logic [1:0]  pan_q[8], pan_d[8];
  logic [6:0]  kc_q[8], kc_d[8];
  logic [5:0]  kf_q[8], kf_d[8];
  logic [19:0] phase_q[8], phase_d[8];
  logic signed [15:0] xl_q, xl_d, xr_q, xr_d;

  logic               tick, evt, dwr, ovf_a, ovf_b;
  logic [7:0]         key_eff;
  logic [2:0]         ch;
  logic signed [15:0] ch_out;
  logic signed [18:0] sum_l, sum_r;

  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    if (v > 19'sd32767)       return 16'sh7FFF;
    else if (v < -19'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    addr_d   = addr_q;
    busy_d   = busy_q;
    bcnt_d   = bcnt_q;
    key_d    = key_q;
    clka_d   = clka_q;
    clkb_d   = clkb_q;
    ctrl_d   = ctrl_q;
    ct_d     = ct_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    pre_b_d  = pre_b_q;
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    pan_d    = pan_q;
    kc_d     = kc_q;
    kf_d     = kf_q;
    phase_d  = phase_q;
    xl_d     = xl_q;
    xr_d     = xr_q;
    ovf_a    = 1'b0;
    ovf_b    = 1'b0;
    ch       = addr_q[2:0];

    tick     = cen & cen_p1;
    evt      = tick & (tcnt_q == 5'd31);
    dwr      = ~cs_n & ~wr_n & a0;
    tcnt_d   = tick ? tcnt_q + 5'd1 : tcnt_q;
    sample_d = evt;

    if (busy_q && tick) begin
      bcnt_d = bcnt_q + 5'd1;
      if (bcnt_q == 5'd31) busy_d = 1'b0;
    end
    if (dwr) begin
      busy_d = 1'b1;
      bcnt_d = 5'd0;
    end
    if (~cs_n & ~wr_n & ~a0) addr_d = din;

    if (evt && ctrl_q[0]) begin
      if (cnt_a_q == 10'h3FF) begin
        cnt_a_d = clka_q;
        ovf_a   = 1'b1;
      end else begin
        cnt_a_d = cnt_a_q + 10'd1;
      end
    end
    if (evt && ctrl_q[1]) begin
      pre_b_d = pre_b_q + 4'd1;
      if (pre_b_q == 4'hF) begin
        if (cnt_b_q == 8'hFF) begin
          cnt_b_d = clkb_q;
          ovf_b   = 1'b1;
        end else begin
          cnt_b_d = cnt_b_q + 8'd1;
        end
      end
    end

    if (dwr) begin
      casez (addr_q)
        8'h08: key_d[din[2:0]] = |din[6:3];
        8'h10: clka_d[9:2] = din;
        8'h11: clka_d[1:0] = din[1:0];
        8'h12: clkb_d = din;
        8'h14: begin
          ctrl_d = {din[7], din[3:0]};
          if (din[0] && !ctrl_q[0]) cnt_a_d = clka_q;
          if (din[1] && !ctrl_q[1]) begin
            cnt_b_d = clkb_q;
            pre_b_d = 4'd0;
          end
          if (din[4]) flag_a_d = 1'b0;
          if (din[5]) flag_b_d = 1'b0;
        end
        8'h1B:         ct_d = din[7:6];
        8'b0010_0???:  pan_d[ch] = din[7:6];
        8'b0010_1???:  kc_d[ch]  = din[6:0];
        8'b0011_0???:  kf_d[ch]  = din[7:2];
        default: ;
      endcase
    end
    // Overflow is applied after the write so a same-tick clear loses to the set.
    if (ovf_a) flag_a_d = 1'b1;
    if (ovf_b) flag_b_d = 1'b1;

    key_eff = key_q | {8{csm_q}};
    sum_l   = 19'sd0;
    sum_r   = 19'sd0;
    ch_out  = 16'sd0;
    for (int i = 0; i < 8; i++) begin
      if (!key_eff[i])  phase_d[i] = 20'd0;
      else if (evt)     phase_d[i] = phase_q[i] + {7'd0, kc_q[i], kf_q[i]};
      ch_out = !key_eff[i] ? 16'sd0 : (phase_q[i][19] ? -CH_AMP : CH_AMP);
      if (pan_q[i][1]) sum_r = sum_r + {{3{ch_out[15]}}, ch_out};
      if (pan_q[i][0]) sum_l = sum_l + {{3{ch_out[15]}}, ch_out};
    end
    if (evt) begin
      xl_d = sat16(sum_l);
      xr_d = sat16(sum_r);
    end
  end

`ifdef CSM_EN
  assign csm_d = evt ? (ovf_a & ctrl_q[4]) : csm_q;
`else
  logic unused_csm;
  assign csm_d      = 1'b0;
  assign unused_csm = ctrl_q[4];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      busy_q   <= 1'b0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      sample_q <= 1'b0;
      key_q    <= '0;
      clka_q   <= '0;
      clkb_q   <= '0;
      ctrl_q   <= '0;
      ct_q     <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      pre_b_q  <= '0;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      csm_q    <= 1'b0;
      xl_q     <= '0;
      xr_q     <= '0;
      // NOTE: the per-channel arrays are plain flops, not a RAM, so they take the reset like everything else.
      for (int i = 0; i < 8; i++) begin
        pan_q[i]   <= '0;
        kc_q[i]    <= '0;
        kf_q[i]    <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      // NOTE: state is updated with <= only; all = assignments live in the always_comb above.
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      sample_q <= sample_d;
      key_q    <= key_d;
      clka_q   <= clka_d;
      clkb_q   <= clkb_d;
      ctrl_q   <= ctrl_d;
      ct_q     <= ct_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      pre_b_q  <= pre_b_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      csm_q    <= csm_d;
      xl_q     <= xl_d;
      xr_q     <= xr_d;
      pan_q    <= pan_d;
      kc_q     <= kc_d;
      kf_q     <= kf_d;
      phase_q  <= phase_d;
    end
  end

  assign dout     = {busy_q, 5'd0, flag_b_q, flag_a_q};
  assign ct1      = ct_q[0];
  assign ct2      = ct_q[1];
  assign irq_n    = ~((flag_a_q & ctrl_q[2]) | (flag_b_q & ctrl_q[3]));
  assign sample   = sample_q;
  assign xleft    = xl_q;
  assign xright   = xr_q;
  assign left     = {xl_q[15:6], 6'd0};
  assign right    = {xr_q[15:6], 6'd0};
  assign dacleft  = xl_q ^ 16'h8000;
  assign dacright = xr_q ^ 16'h8000;

endmodule

// File: tb/tb_jt51_lite.sv
// Directed bench for jt51_lite: reset, busy, sample strobe, timers A/B with IRQ, tone/mixer path, reset mid-operation.
module tb_jt51_lite;

  logic        clk = 1'b0;
  logic        rst, cen, cen_p1, cs_n, wr_n, a0;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        ct1, ct2, irq_n, sample;
  logic [15:0] left, right, xleft, xright, dacleft, dacright;

  int checks = 0;
  int passed = 0;

  jt51_lite dut (
    .clk(clk), .rst(rst), .cen(cen), .cen_p1(cen_p1),
    .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .dout(dout), .ct1(ct1), .ct2(ct2), .irq_n(irq_n), .sample(sample),
    .left(left), .right(right), .xleft(xleft), .xright(xright),
    .dacleft(dacleft), .dacright(dacright)
  );

  always #140 clk = ~clk;

  initial begin
    cen_p1 = 1'b0;
    forever @(negedge clk) cen_p1 = ~cen_p1;
  end

  initial begin
    #(280 * 100000);
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drive one bus cycle so that the capturing posedge is also a tick.
  task automatic bus_write(input logic ad, input logic [7:0] d);
    @(negedge clk); #1;
    if (!cen_p1) begin
      @(negedge clk); #1;
    end
    cs_n = 1'b0; wr_n = 1'b0; a0 = ad; din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    bus_write(1'b0, addr);
    bus_write(1'b1, data);
  endtask

  task automatic wait_sample(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample && n < 200);
    if (!sample) check("sample_timeout", 32'(sample), 32'd1);
  endtask

  task automatic wait_samples(input int k);
    int n;
    repeat (k) wait_sample(n);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (dout[7] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; cen = 1'b1; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dout",     32'(dout),     32'h00);
    check("rst_irq_n",    32'(irq_n),    32'd1);
    check("rst_sample",   32'(sample),   32'd0);
    check("rst_left",     32'(left),     32'h0000);
    check("rst_dacleft",  32'(dacleft),  32'h8000);
    check("rst_dacright", 32'(dacright), 32'h8000);
    check("rst_ct",       32'({ct2, ct1}), 32'd0);
    rst = 1'b0;

    // Busy: 32 ticks = 64 clk with cen_p1 at half rate
    write_reg(8'h1B, 8'hC0);
    check("busy_set", 32'(dout[7]), 32'd1);
    count_busy(n);
    check("busy_clks", 32'(n), 32'd64);
    check("ct1", 32'(ct1), 32'd1);
    check("ct2", 32'(ct2), 32'd1);

    // A data write while busy restarts the count
    write_reg(8'h1B, 8'h40);
    repeat (20) @(negedge clk);
    bus_write(1'b1, 8'h80);
    count_busy(n);
    check("busy_restart_clks", 32'(n), 32'd64);
    check("ct_after_rewrite", 32'({ct2, ct1}), 32'b10);

    // Sample strobe
    wait_sample(n);
    @(negedge clk);
    check("sample_width", 32'(sample), 32'd0);
    wait_sample(n);
    check("sample_period", 32'(n), 32'd63);

    // Timer A with CLKA = 1023: one-sample period
    write_reg(8'h10, 8'hFF);
    write_reg(8'h11, 8'h03);
    write_reg(8'h14, 8'h05);
    check("ta_flag_pre", 32'(dout[0]), 32'd0);
    check("ta_irq_pre",  32'(irq_n),   32'd1);
    wait_sample(n);
    check("ta_flag", 32'(dout[0]), 32'd1);
    check("ta_irq",  32'(irq_n),   32'd0);
    write_reg(8'h14, 8'h15);
    check("ta_clr_flag", 32'(dout[0]), 32'd0);
    check("ta_clr_irq",  32'(irq_n),   32'd1);
    write_reg(8'h14, 8'h30);

    // Timer B with CLKB = 0xFE: 32-sample period
    write_reg(8'h12, 8'hFE);
    write_reg(8'h14, 8'h0A);
    wait_samples(31);
    check("tb_flag_31", 32'(dout[1]), 32'd0);
    check("tb_irq_31",  32'(irq_n),   32'd1);
    wait_sample(n);
    check("tb_flag_32", 32'(dout[1]), 32'd1);
    check("tb_irq_32",  32'(irq_n),   32'd0);
    write_reg(8'h14, 8'h22);
    check("tb_clr_flag", 32'(dout[1]), 32'd0);
    wait_samples(32);
    check("tb_flag_noen", 32'(dout[1]), 32'd1);
    check("tb_irq_noen",  32'(irq_n),   32'd1);
    write_reg(8'h14, 8'h20);
    check("tb_stop_flags", 32'(dout[1:0]), 32'd0);

    // Tone: ch0 both sides with step 0x1FFF, ch1 right only with step 0
    write_reg(8'h20, 8'hC0);
    write_reg(8'h21, 8'h80);
    write_reg(8'h28, 8'h7F);
    write_reg(8'h30, 8'hFC);
    write_reg(8'h08, 8'h79);
    write_reg(8'h08, 8'h78);
    wait_samples(10);
    check("tone_left_hi",     32'(left),     32'h0800);
    check("tone_xleft_hi",    32'(xleft),    32'h0800);
    check("tone_right_sum",   32'(right),    32'h1000);
    check("tone_xright_sum",  32'(xright),   32'h1000);
    check("tone_dacleft_hi",  32'(dacleft),  32'h8800);
    check("tone_dacright_hi", 32'(dacright), 32'h9000);
    wait_samples(60);
    check("tone_left_lo",    32'(left),    32'hF800);
    check("tone_xleft_lo",   32'(xleft),   32'hF800);
    check("tone_right_cancel", 32'(right), 32'h0000);
    check("tone_dacleft_lo", 32'(dacleft), 32'h7800);
    wait_samples(65);
    check("tone_left_wrap", 32'(left), 32'h0800);
    write_reg(8'h08, 8'h00);
    wait_sample(n);
    check("keyoff_left",    32'(left),    32'h0000);
    check("keyoff_dacleft", 32'(dacleft), 32'h8000);
    check("keyoff_right",   32'(right),   32'h0800);

    // Reset in the middle of activity
    write_reg(8'h08, 8'h78);
    write_reg(8'h14, 8'h05);
    wait_samples(2);
    check("pre_rst_left", 32'(left),  32'h0800);
    check("pre_rst_irq",  32'(irq_n), 32'd0);
    @(negedge clk); #10;
    rst = 1'b1;
    #1;
    check("mid_rst_dout",    32'(dout),    32'h00);
    check("mid_rst_irq_n",   32'(irq_n),   32'd1);
    check("mid_rst_left",    32'(left),    32'h0000);
    check("mid_rst_right",   32'(right),   32'h0000);
    check("mid_rst_dacleft", 32'(dacleft), 32'h8000);
    check("mid_rst_ct",      32'({ct2, ct1}), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jt51_lite.md
Name: jt51_lite

Overview:
- Reduced YM2151-compatible (OPM) sound block: CPU register port, timers A/B with IRQ, CT1/CT2 outputs, busy flag, sample strobe.
- Eight square-wave tone channels with pan, mixed to stereo.
- Sits behind the host CPU bus as a drop-in OPM-style peripheral; the full FM engine is out of scope.

Parameters:
- CH_AMP, 16'd2048, signed amplitude of one keyed channel on a panned side.

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous reset, active high
- cen  in  1  main clock enable
- cen_p1  in  1  half-rate enable; all internal logic advances only when cen & cen_p1 ("tick")
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low, sampled each clk
- a0  in  1  0 = address write, 1 = data write
- din  in  8  write data
- dout  out  8  status: [7] busy, [1] timer B flag, [0] timer A flag, others 0
- ct1  out  1  reg 0x1B bit 6
- ct2  out  1  reg 0x1B bit 7
- irq_n  out  1  active-low interrupt, not synchronized
- sample  out  1  one-clk pulse marking a new output sample
- left  out  16  signed, low-resolution left (xleft with bits [5:0] forced to 0)
- right  out  16  signed, low-resolution right
- xleft  out  16  signed, full-resolution left
- xright  out  16  signed, full-resolution right
- dacleft  out  16  unsigned left, equal to xleft ^ 16'h8000
- dacright  out  16  unsigned right, equal to xright ^ 16'h8000

Behaviour:
- Reset: all registers 0; busy 0; flags 0; irq_n 1; ct1/ct2 0; sample 0; all audio outputs 0 (dac* = 16'h8000); tick counter 0.
- Writes accepted on any clk with cs_n = 0 and wr_n = 0, independent of cen.
  - a0 = 0: latch din as the register address.
  - a0 = 1: write din to the latched register and set busy.
- Busy clears after 32 ticks. A data write while busy is still performed and restarts the count.
- Sample period is 32 ticks, from a 5-bit tick counter. sample is high for exactly one clk, on the tick where the counter wraps 31 to 0.
- Registers:
  - 0x08 key-on: ch = din[2:0]; the channel is keyed while din[6:3] != 0.
  - 0x10 CLKA[9:2], 0x11[1:0] CLKA[1:0], 0x12 CLKB.
  - 0x14 timer control: [0] load/run A, [1] load/run B, [2] IRQ enable A, [3] IRQ enable B. Writing [4]=1 clears flag A; writing [5]=1 clears flag B (self-clearing, not stored).
  - 0x1B: [7] ct2, [6] ct1.
  - 0x20+ch: [7] right enable, [6] left enable.
  - 0x28+ch: KC[6:0].
  - 0x30+ch: KF in [7:2].
  - All other addresses are ignored.
- Timer A: 10-bit up-counter stepped once per sample while run A = 1.
  - On the 0-to-1 edge of run A, the counter loads CLKA.
  - Overflow from 1023 reloads CLKA and sets flag A. Period = (1024 - CLKA) samples.
  - run A = 0 holds the counter.
- Timer B: 8-bit up-counter stepped every 16 samples (4-bit prescaler, reset on load).
  - Loads CLKB on the 0-to-1 edge of run B.
  - Overflow from 255 reloads CLKB and sets flag B. Period = 16 * (256 - CLKB) samples.
- Flags set even when their IRQ enable is 0. Overflow and a clear in the same tick: the set wins.
- irq_n = ~((flagA & enA) | (flagB & enB)), combinational from registers.
- Tone channels:
  - 20-bit phase accumulator per channel; each sample, add the 13-bit {KC, KF} zero-extended.
  - Channel output = +CH_AMP when phase[19] = 0, else -CH_AMP. Output is 0 when not keyed.
  - Key-off zeroes the phase.
- Mixer: per side, sum the enabled channel outputs in 19 bits, saturate to 16-bit signed, and register on the sample pulse.

Optional Feature:
- CSM_EN defined: when reg 0x14 bit 7 (CSM) is 1, each timer A overflow keys on all 8 channels for one sample period, then restores their register key state.
- CSM_EN undefined: bit 7 is stored but has no effect.

Test Plan:
- Reset: assert rst mid-operation -> dout = 8'h00, irq_n = 1, left = 0, dacleft = 16'h8000, all immediately.
- Busy timing: clk 280 ns, cen = 1, cen_p1 toggling; write addr 0x1B then data 0xC0 -> busy = 1 for 64 clk, then 0; ct1 = 1, ct2 = 1.
- Sample strobe: same clocking -> sample is a 1-clk pulse every 64 clk.
- Timer A: write 0x10 = 0xFF, 0x11 = 0x03, 0x14 = 0x05 -> dout[0] = 1 and irq_n = 0 after 1 sample; write 0x14 = 0x15 -> irq_n returns to 1.
- Timer B: write 0x12 = 0xFE, 0x14 = 0x0A -> flag B and irq_n = 0 after 32 samples; enable 0 -> flag set, irq_n stays 1.
- Tone path: write 0x20 = 0x40, 0x28 = 0x7F, 0x30 = 0xFC, 0x08 = 0x78 -> left alternates +2048 / -2048 (low 6 bits 0) with period 128 samples; right = 0; key off (0x08 = 0x00) -> left = 0.
